mmc1_sync_mapper: RTL

- Clocked, parametrised successor of the MMC1-class serial-load mapper.
- Samples the CPU bus on a fast board clock instead of clocking on nCPU_ROMSEL.
- Adds a consecutive-write filter (RMW double writes), a WRAM disable bit, an optional outer PRG bank taken from CHR bank 0, and commit/debug strobes.
- Sits between the cartridge edge connector and the PRG/CHR/WRAM chip selects.

---
 rtl/mmc1_pkg.sv | 29 ++
 rtl/m2_bus_sampler.sv | 74 +++++++
 rtl/mmc1_sync_mapper.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mmc1_pkg.sv
// Shared definitions for the clocked MMC1-class mapper.
// Holds register-select codes, the control register reset value and the
// mirroring / PRG banking mode encodings carried in control[1:0] / [3:2].
package mmc1_pkg;

    // Register select, taken from {CPU_A14, CPU_A13} of the fifth write.
    localparam logic [1:0] REG_CTRL = 2'b00;
    localparam logic [1:0] REG_CHR0 = 2'b01;
    localparam logic [1:0] REG_CHR1 = 2'b10;
    localparam logic [1:0] REG_PRG  = 2'b11;

    // PRG mode 11 (fix last bank at $C000), 8 KB CHR mode, one-screen low.
    localparam logic [4:0] CTRL_RESET = 5'b01100;

    typedef enum logic [1:0] {
        MirOneLow     = 2'b00,
        MirOneHigh    = 2'b01,
        MirVertical   = 2'b10,
        MirHorizontal = 2'b11
    } mirror_e;

    typedef enum logic [1:0] {
        PrgMode32kA     = 2'b00,
        PrgMode32kB     = 2'b01,
        PrgModeFixFirst = 2'b10,
        PrgModeFixLast  = 2'b11
    } prg_mode_e;

endpackage

// File: rtl/m2_bus_sampler.sv
// CPU bus sampler for the mapper.
// Synchronises M2 and the bus pins to the board clock through identical
// 2-FF chains, latches the bus while M2 is high, and emits a one-clock
// write event on each M2 fall that ends a mapper write ($8000-$FFFF, RW=0).
// Ports:
//   clk, rst            board clock, synchronous active-high reset
//   m2, romsel_n, rw_n  raw CPU control pins
//   a13, a14, d0, d7    raw CPU address / data pins
//   wr_evt              one-clock pulse: accepted mapper write
//   wr_a                {A14, A13} of that write
//   wr_d0, wr_d7        data bits of that write
module m2_bus_sampler #(
    parameter int WRITE_FILTER = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m2,
    input  logic       romsel_n,
    input  logic       rw_n,
    input  logic       a13,
    input  logic       a14,
    input  logic       d0,
    input  logic       d7,
    output logic       wr_evt,
    output logic [1:0] wr_a,
    output logic       wr_d0,
    output logic       wr_d7
);

    // Bit order: {m2, romsel_n, rw_n, a14, a13, d7, d0}
    localparam logic [6:0] SYNC_IDLE = 7'b0110000;
    localparam logic [5:0] BUS_IDLE  = 6'b110000;

    logic [6:0] sync1;
    logic [6:0] sync2;
    logic [5:0] bus;
    logic       m2_prev;
    logic       prev_wr;
    logic       fall_evt;
    logic       raw_wr;
    logic       filt_en;

    assign filt_en  = (WRITE_FILTER != 0);
    assign fall_evt = m2_prev & ~sync2[6];
    assign raw_wr   = fall_evt & ~bus[5] & ~bus[4];
    // Second write of a read-modify-write lands on the very next M2 cycle.
    assign wr_evt   = raw_wr & ~(filt_en & prev_wr);

    assign wr_a  = bus[3:2];
    assign wr_d7 = bus[1];
    assign wr_d0 = bus[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= SYNC_IDLE;
            sync2   <= SYNC_IDLE;
            bus     <= BUS_IDLE;
            m2_prev <= 1'b0;
            prev_wr <= 1'b0;
        end else begin
            sync1   <= {m2, romsel_n, rw_n, a14, a13, d7, d0};
            sync2   <= sync1;
            m2_prev <= sync2[6];
            // Holding the last M2-high sample gives a stable bus at the fall.
            if (sync2[6]) begin
                bus <= sync2[5:0];
            end
            if (fall_evt) begin
                prev_wr <= wr_evt;
            end
        end
    end

endmodule

// File: rtl/mmc1_sync_mapper.sv
// Clocked MMC1-class serial-load mapper.
// Five LSB-first writes to $8000-$FFFF load a 5-bit register chosen by
// {A14, A13}; a write with D7=1 resets the shift. Bank and chip-select
// decode is combinational from the registers and raw pins.
// Ports:
//   CLK, RST                        board clock, synchronous active-high reset
//   CPU_M2, nCPU_ROMSEL, nCPU_RW    CPU bus control
//   CPU_A13, CPU_A14, CPU_D0, CPU_D7 register select / serial data
//   PPU_A12, PPU_A11, PPU_A10       PPU address
//   CIRAM_A10                       nametable select
//   PRG_A, CHR_A                    banked address lines (A14+, A12+)
//   nPRG_CE, nWRAM_CE               active-low chip enables
//   REG_COMMIT                      one-clock pulse on a 5-bit commit
//   SHIFT_CNT                       bits held in the shift register
module mmc1_sync_mapper #(
    parameter int PRG_BANK_BITS = 4,
    parameter int CHR_BANK_BITS = 5,
    parameter int OUTER_PRG     = 0,
    parameter int WRITE_FILTER  = 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 CPU_M2,
    input  logic                                 nCPU_ROMSEL,
    input  logic                                 nCPU_RW,
    input  logic                                 CPU_A13,
    input  logic                                 CPU_A14,
    input  logic                                 CPU_D0,
    input  logic                                 CPU_D7,
    input  logic                                 PPU_A12,
    input  logic                                 PPU_A11,
    input  logic                                 PPU_A10,
    output logic                                 CIRAM_A10,
    output logic [PRG_BANK_BITS+OUTER_PRG-1:0]   PRG_A,
    output logic [CHR_BANK_BITS-1:0]             CHR_A,
    output logic                                 nPRG_CE,
    output logic                                 nWRAM_CE,
    output logic                                 REG_COMMIT,
    output logic [2:0]                           SHIFT_CNT
);
    import mmc1_pkg::*;

    logic       wr_evt;
    logic [1:0] wr_a;
    logic       wr_d0;
    logic       wr_d7;

    logic [4:0] control;
    logic [4:0] chr0;
    logic [4:0] chr1;
    logic [4:0] prg;
    logic [3:0] shift;
    logic [2:0] shift_cnt;
    logic       reg_commit;
    logic [4:0] commit_value;

    logic [PRG_BANK_BITS-1:0] prg_b;
    logic [PRG_BANK_BITS-1:0] prg_bank;
    logic [CHR_BANK_BITS-1:0] chr_bank;
    logic                     ciram;

    m2_bus_sampler #(
        .WRITE_FILTER (WRITE_FILTER)
    ) u_sampler (
        .clk      (CLK),
        .rst      (RST),
        .m2       (CPU_M2),
        .romsel_n (nCPU_ROMSEL),
        .rw_n     (nCPU_RW),
        .a13      (CPU_A13),
        .a14      (CPU_A14),
        .d0       (CPU_D0),
        .d7       (CPU_D7),
        .wr_evt   (wr_evt),
        .wr_a     (wr_a),
        .wr_d0    (wr_d0),
        .wr_d7    (wr_d7)
    );

    // Shift fills from the top, so after four bits the first one is in bit 0.
    assign commit_value = {wr_d0, shift};

    always_ff @(posedge CLK) begin
        if (RST) begin
            control    <= CTRL_RESET;
            chr0       <= 5'd0;
            chr1       <= 5'd0;
            prg        <= 5'd0;
            shift      <= 4'd0;
            shift_cnt  <= 3'd0;
            reg_commit <= 1'b0;
        end else begin
            reg_commit <= 1'b0;
            if (wr_evt) begin
                if (wr_d7) begin
                    shift        <= 4'd0;
                    shift_cnt    <= 3'd0;
                    control[3:2] <= 2'b11;
                end else if (shift_cnt < 3'd4) begin
                    shift     <= {wr_d0, shift[3:1]};
                    shift_cnt <= shift_cnt + 3'd1;
                end else begin
                    unique case (wr_a)
                        REG_CTRL: control <= commit_value;
                        REG_CHR0: chr0    <= commit_value;
                        REG_CHR1: chr1    <= commit_value;
                        REG_PRG:  prg     <= commit_value;
                        default:  ;
                    endcase
                    shift      <= 4'd0;
                    shift_cnt  <= 3'd0;
                    reg_commit <= 1'b1;
                end
            end
        end
    end

    assign prg_b = prg[PRG_BANK_BITS-1:0];

    always_comb begin
        prg_bank = '1;
        unique case (prg_mode_e'(control[3:2]))
            PrgMode32kA,
            PrgMode32kB:     prg_bank = {prg_b[PRG_BANK_BITS-1:1], CPU_A14};
            PrgModeFixFirst: prg_bank = CPU_A14 ? prg_b : '0;
            PrgModeFixLast:  prg_bank = CPU_A14 ? '1 : prg_b;
            default:         prg_bank = '1;
        endcase
    end

    generate
        if (OUTER_PRG != 0) begin : g_outer
            // 512 KB boards take the outer 256 KB select from CHR bank 0.
            assign PRG_A = {chr0[4], prg_bank};
        end else begin : g_no_outer
            assign PRG_A = prg_bank;
        end
    endgenerate

    always_comb begin
        chr_bank = '0;
        if (control[4]) begin
            chr_bank = PPU_A12 ? chr1[CHR_BANK_BITS-1:0] : chr0[CHR_BANK_BITS-1:0];
        end else begin
            chr_bank = {chr0[CHR_BANK_BITS-1:1], PPU_A12};
        end
    end

    always_comb begin
        ciram = 1'b0;
        unique case (mirror_e'(control[1:0]))
            MirOneLow:     ciram = 1'b0;
            MirOneHigh:    ciram = 1'b1;
            MirVertical:   ciram = PPU_A10;
            MirHorizontal: ciram = PPU_A11;
            default:       ciram = 1'b0;
        endcase
    end

    assign CHR_A      = chr_bank;
    assign CIRAM_A10  = ciram;
    assign nPRG_CE    = nCPU_ROMSEL | ~nCPU_RW;
    assign nWRAM_CE   = ~(CPU_M2 & nCPU_ROMSEL & CPU_A14 & CPU_A13 & ~prg[4]);
    assign REG_COMMIT = reg_commit;
    assign SHIFT_CNT  = shift_cnt;

endmodule
